// File: rtl/tb_retire_serializer.sv
// Commit serializer: compacts up to three retirements per cycle into a FIFO,
// drains one entry per cycle over valid/ready, tags every retirement with a
// running sequence number, counts drops and runs a no-retire watchdog.
module tb_retire_serializer #(
  parameter int DEPTH       = 16,
  parameter int WDOG_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     retire0_vld,
  input  logic                     retire1_vld,
  input  logic                     retire2_vld,
  input  logic [39:0]              retire0_pc,
  input  logic [39:0]              retire1_pc,
  input  logic [39:0]              retire2_pc,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [1:0]               out_idx,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_seq,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     ovfl,
  output logic [15:0]              drop_cnt,
  input  logic                     wdog_clr,
  output logic                     wdog_expire
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WW-1:0] WDOG_C  = WW'(WDOG_CYCLES);

  // FIFO storage (contents are don't-care until written, so no reset)
  logic [1:0]  idx_mem_q [DEPTH];
  logic [39:0] pc_mem_q  [DEPTH];
  logic [31:0] seq_mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [31:0]   seq_ctr_q, seq_ctr_d;
  logic          ovfl_q, ovfl_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wdog_expire_q, wdog_expire_d;

  logic [2:0]    vld_vec_s;
  logic [1:0]    n_vld_s;
  logic [1:0]    slot_port_s [3];
  logic [39:0]   slot_pc_s   [3];
  logic [CW-1:0] free_s;
  logic [1:0]    n_push_s;
  logic [1:0]    n_drop_s;
  logic          pop_s;
  logic [16:0]   drop_sum_s;

  assign vld_vec_s = {retire2_vld, retire1_vld, retire0_vld};

  // Compact the valid ports into slots 0..n_vld-1, lowest port first
  always_comb begin
    n_vld_s        = 2'd0;
    slot_port_s[0] = 2'd0;
    slot_port_s[1] = 2'd0;
    slot_port_s[2] = 2'd0;
    case (vld_vec_s)
      3'b000: n_vld_s = 2'd0;
      3'b001: begin n_vld_s = 2'd1; slot_port_s[0] = 2'd0; end
      3'b010: begin n_vld_s = 2'd1; slot_port_s[0] = 2'd1; end
      3'b011: begin n_vld_s = 2'd2; slot_port_s[0] = 2'd0; slot_port_s[1] = 2'd1; end
      3'b100: begin n_vld_s = 2'd1; slot_port_s[0] = 2'd2; end
      3'b101: begin n_vld_s = 2'd2; slot_port_s[0] = 2'd0; slot_port_s[1] = 2'd2; end
      3'b110: begin n_vld_s = 2'd2; slot_port_s[0] = 2'd1; slot_port_s[1] = 2'd2; end
      3'b111: begin
        n_vld_s        = 2'd3;
        slot_port_s[0] = 2'd0;
        slot_port_s[1] = 2'd1;
        slot_port_s[2] = 2'd2;
      end
      default: n_vld_s = 2'd0;
    endcase
  end

  // Route each slot's PC from its source port
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      slot_pc_s[j] = 40'd0;
      case (slot_port_s[j])
        2'd0:    slot_pc_s[j] = retire0_pc;
        2'd1:    slot_pc_s[j] = retire1_pc;
        2'd2:    slot_pc_s[j] = retire2_pc;
        default: slot_pc_s[j] = 40'd0;
      endcase
    end
  end

  // Space is judged on start-of-cycle occupancy; a same-cycle pop frees nothing
  always_comb begin
    free_s = DEPTH_C - fifo_cnt_q;
    if (CW'(n_vld_s) <= free_s) begin
      n_push_s = n_vld_s;
    end else begin
      n_push_s = free_s[1:0];
    end
    n_drop_s = n_vld_s - n_push_s;
  end

  assign pop_s = out_vld & out_rdy;

  // Next-state for pointers, occupancy, sequence and drop accounting
  always_comb begin
    rd_ptr_d   = rd_ptr_q + AW'(pop_s);
    wr_ptr_d   = wr_ptr_q + AW'(n_push_s);
    fifo_cnt_d = fifo_cnt_q + CW'(n_push_s) - CW'(pop_s);
    seq_ctr_d  = seq_ctr_q + 32'(n_vld_s);
    drop_sum_s = {1'b0, drop_cnt_q} + 17'(n_drop_s);
    if (drop_sum_s[16]) begin
      drop_cnt_d = 16'hFFFF;
    end else begin
      drop_cnt_d = drop_sum_s[15:0];
    end
    ovfl_d = ovfl_q | (n_drop_s != 2'd0);
  end

  // Watchdog: clear wins, any retire restarts the count, otherwise saturate
  always_comb begin
    if (wdog_clr) begin
      wd_cnt_d      = {WW{1'b0}};
      wdog_expire_d = 1'b0;
    end else begin
      if (n_vld_s != 2'd0) begin
        wd_cnt_d = {WW{1'b0}};
      end else if (wd_cnt_q < WDOG_C) begin
        wd_cnt_d = wd_cnt_q + {{(WW-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
      wdog_expire_d = wdog_expire_q | (wd_cnt_d == WDOG_C);
    end
  end

  // Write accepted slots into consecutive FIFO locations
  always_ff @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (j < int'(n_push_s)) begin
        idx_mem_q[wr_ptr_q + AW'(j)] <= slot_port_s[j];
        pc_mem_q[wr_ptr_q + AW'(j)]  <= slot_pc_s[j];
        seq_mem_q[wr_ptr_q + AW'(j)] <= seq_ctr_q + 32'(j);
      end
    end
  end

  // Control and status state with asynchronous reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr_q      <= {AW{1'b0}};
      wr_ptr_q      <= {AW{1'b0}};
      fifo_cnt_q    <= {CW{1'b0}};
      seq_ctr_q     <= 32'd0;
      ovfl_q        <= 1'b0;
      drop_cnt_q    <= 16'd0;
      wd_cnt_q      <= {WW{1'b0}};
      wdog_expire_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      seq_ctr_q     <= seq_ctr_d;
      ovfl_q        <= ovfl_d;
      drop_cnt_q    <= drop_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      wdog_expire_q <= wdog_expire_d;
    end
  end

  assign out_vld     = (fifo_cnt_q != {CW{1'b0}});
  assign out_idx     = idx_mem_q[rd_ptr_q];
  assign out_pc      = {24'd0, pc_mem_q[rd_ptr_q]};
  assign out_seq     = seq_mem_q[rd_ptr_q];
  assign fifo_cnt    = fifo_cnt_q;
  assign ovfl        = ovfl_q;
  assign drop_cnt    = drop_cnt_q;
  assign wdog_expire = wdog_expire_q;

endmodule

// File: doc/tb_retire_serializer.md
# tb_retire_serializer

Simulation-side commit serializer between the C910 core's three retire ports and the testbench commit consumer (DPI hart commit hook, trace writer). It captures up to three retirements per cycle, in port order, into a FIFO, then drains one per cycle over a valid/ready interface. Each entry carries a sequence number, so drops are visible. The block also runs the no-retire watchdog and flags FIFO overflow.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4
- WDOG_CYCLES, 50000, consecutive retire-free cycles before watchdog fires; ≥2

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- retire0_vld / retire1_vld / retire2_vld  in  1 each  retire port valid
- retire0_pc / retire1_pc / retire2_pc  in  40 each  retired PC
- out_vld  out  1  head entry valid
- out_rdy  in  1  consumer accepts head
- out_idx  out  2  source retire port of head (0..2)
- out_pc  out  64  head PC, zero-extended from 40 bits
- out_seq  out  32  head sequence number
- fifo_cnt  out  log2(DEPTH)+1  occupancy
- ovfl  out  1  sticky, set on any dropped retirement
- drop_cnt  out  16  dropped retirements, saturating
- wdog_clr  in  1  synchronous clear of watchdog counter and flag
- wdog_expire  out  1  sticky watchdog flag

## Operation
- n_vld = number of asserted retireN_vld (0..3). Valid ports are compacted in order 0,1,2.
- free = DEPTH − fifo_cnt, taken at the start of the cycle. A pop in the same cycle does not add space.
- Push n_push = min(n_vld, free) entries, always the lowest-indexed valid ports first. The remaining n_vld − n_push are dropped.
- Each entry stores {idx, pc, seq}. The k-th valid port this cycle (k = 0..n_vld−1) gets seq_ctr + k, dropped entries included.
- seq_ctr += n_vld every cycle. It is 32-bit and wraps at 2^32, so a drop shows up as a seq gap at the consumer.
- Drops: if n_vld > n_push, set ovfl and add the drop count to drop_cnt, saturating at 0xFFFF.
- Pop: when out_vld && out_rdy, advance rd_ptr. Pointers are log2(DEPTH) bits and wrap naturally.
- fifo_cnt_next = fifo_cnt + n_push − pop.
- out_vld = (fifo_cnt != 0). out_idx, out_pc and out_seq are a combinational read of the head entry and hold stable while out_vld && !out_rdy.
- Watchdog:
  - wd_cnt clears on any cycle with n_vld > 0, regardless of drops; otherwise it increments, saturating at WDOG_CYCLES.
  - wdog_expire sets at the edge where wd_cnt reaches WDOG_CYCLES, i.e. after WDOG_CYCLES consecutive idle cycles.
  - wdog_expire is sticky until wdog_clr or reset. wdog_clr takes priority over increment and set in the same cycle.

## Timing
- Reset values: out_vld 0, fifo_cnt 0, rd_ptr/wr_ptr 0, seq_ctr 0, ovfl 0, drop_cnt 0, wd_cnt 0, wdog_expire 0. out_idx/out_pc/out_seq are don't-care while out_vld=0.
- Push-to-output latency is one cycle: retirement sampled at edge N gives out_vld=1 after edge N when the FIFO was empty. There is no bypass.
- Throughput: up to 3 pushes and 1 pop per cycle. A sustained 3-wide retire overflows after about DEPTH/2 cycles.
- Full FIFO with simultaneous pop: all pushes that cycle drop, and the pop still completes.
- Reset mid-operation clears all contents and counters immediately and asynchronously. Entries in flight are lost with no out_vld glitch.

## Test plan
- Single retire: retire1_vld=1, pc=0x80000000 at cycle 5, out_rdy=1 → next cycle out_vld=1, out_idx=1, out_pc=0x0000000080000000, out_seq=0. fifo_cnt returns to 0 one cycle later.
- Triple retire: all three valid in one cycle with pcs 0x100/0x104/0x108 → three consecutive pops with idx 0,1,2 and seq 0,1,2. Then retire0+retire2 valid → idx 0,2 with seq 3,4.
- Overflow: DEPTH=16, out_rdy=0, 3 retires/cycle for 6 cycles → fifo_cnt=16 after cycle 6, ovfl=1, drop_cnt=2. Drained seqs are 0..15 in order. A subsequent retire gets seq 18.
- Full plus pop: fifo_cnt=16, out_rdy=1, retire0 valid → that retire drops (drop_cnt+1), fifo_cnt=15, and the head advances.
- Watchdog: WDOG_CYCLES=8 with no retire → wdog_expire rises after the 8th idle edge. A retire at idle cycle 7 prevents it. wdog_clr drops the flag the next cycle.
- Reset mid-run: FIFO holding 5 entries, rst_b low for 1 cycle → all outputs return to their reset values. The next retire gets seq 0.
